// File: rtl/ysyx_23060208_lsu.sv
`timescale 1ns/1ps
// ysyx_23060208_lsu: single-outstanding load/store unit bridging a CPU request port to AXI-lite.
//   Parameters: DATA_WIDTH (32 or 64), NBYTES (byte lanes per beat).
//   Ports: clk, rst (asynchronous, active-low);
//          req_*  : request handshake plus store/size/unsigned/addr/wdata qualifiers;
//          resp_* : one-cycle completion pulse with load flag, extended load data and error;
//          aw*/w*/b* : AXI-lite write channels; ar*/r* : AXI-lite read channels.
//   Macro YSYX_23060208_MISALIGN_TRAP_EN: when defined, a misaligned access produces no bus
//   traffic and completes the next cycle with resp_err=1.
module ysyx_23060208_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_load,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [NBYTES-1:0]     wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);
  localparam int OW = $clog2(NBYTES);
  localparam bit NARROW = DATA_WIDTH == 32;
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d;
  logic uns_q, uns_d, store_q, store_d, err_q, err_d, aw_q, aw_d, w_q, w_d;
  logic mis, aw_hs, w_hs, unused;
  logic [OW-1:0] off;
  logic [7:0] pad;
  logic [DATA_WIDTH-1:0] sh, al, ext;
  logic signed [DATA_WIDTH-1:0] sx;
  assign unused = ^{rresp[0], bresp[0]};
`ifdef YSYX_23060208_MISALIGN_TRAP_EN
  assign mis = |(req_addr[2:0] & ((3'd1 << req_size) - 3'd1));
`else
  assign mis = 1'b0;
`endif
  // aw_q / w_q remember a completed handshake so each valid drops independently
  assign aw_hs = aw_q | awready;
  assign w_hs = w_q | wready;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    uns_d = uns_q;
    store_d = store_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    aw_d = aw_q;
    w_d = w_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        size_d = req_size;
        uns_d = req_unsigned;
        store_d = req_store;
        wdata_d = req_wdata;
        err_d = mis;
        state_d = mis ? RESP : req_store ? WR_AW : RD_A;
      end
      RD_A: state_d = arready ? RD_D : RD_A;
      RD_D: if (rvalid) begin
        rdata_d = rdata;
        err_d = rresp[1] | (NARROW && size_q == 2'd3);
        state_d = RESP;
      end
      WR_AW: begin
        aw_d = aw_hs & ~w_hs;
        w_d = w_hs & ~aw_hs;
        state_d = (aw_hs && w_hs) ? WR_B : WR_AW;
      end
      WR_B: if (bvalid) begin
        err_d = bresp[1];
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      uns_q <= uns_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      aw_q <= aw_d;
      w_q <= w_d;
    end
  end
  assign off = addr_q[OW-1:0];
  assign req_ready = state_q == IDLE;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arvalid = state_q == RD_A;
  assign rready = state_q == RD_D;
  assign awvalid = state_q == WR_AW && !aw_q;
  assign wvalid = state_q == WR_AW && !w_q;
  assign bready = state_q == WR_B;
  assign wdata = (state_q == WR_AW) ? wdata_q << {off, 3'b000} : '0;
  // lanes shifted past the top byte are simply dropped by the truncation
  assign wstrb = (state_q == WR_AW) ? NBYTES'(((16'd1 << (5'd1 << size_q)) - 16'd1) << off) : '0;
  // align the accessed bytes to bit 0, park them at the top, then shift back down to extend
  assign sh = rdata_q >> {off, 3'b000};
  assign pad = 8'(DATA_WIDTH - (8 << size_q));
  assign al = sh << pad;
  assign sx = $signed(al) >>> pad;
  assign ext = uns_q ? al >> pad : sx;
  assign resp_valid = state_q == RESP;
  assign resp_load = resp_valid && !store_q;
  assign resp_err = resp_valid && err_q;
  assign resp_rdata = (resp_load && !err_q) ? ext : '0;
endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_23060208_lsu;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 0, req_ready, req_store = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_load, resp_err;
  logic [31:0] resp_rdata, awaddr, wdata, araddr;
  logic [31:0] rdata = 0;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [3:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  int errors = 0, checks = 0;

  ysyx_23060208_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_load(resp_load), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit st; bit [1:0] sz; bit uns; bit [31:0] addr, wd, rd; bit [1:0] rr, br;
    int aw_d, w_d, ar_d, r_d, b_d;
  } acc_t;
  typedef struct { bit [31:0] rdata; bit err; int cyc; bit [3:0] strb; bit [31:0] wdata; bit bus; } exp_t;
  typedef struct {
    bit got; int cyc; bit [31:0] rdata; bit err, load, saw_ar, saw_aw, saw_w;
    bit [31:0] araddr, awaddr, wdata; bit [3:0] strb; int viol;
  } res_t;
  typedef struct { acc_t a; exp_t e; } vec_t;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: byte-lane arithmetic and an idealised slave-latency count.
  function automatic exp_t model(input acc_t a);
    exp_t e;
    int off, nb;
    bit [63:0] v, m;
    off = int'(a.addr % 4);
    nb = 1 << a.sz;
    e.bus = 1;
`ifdef YSYX_23060208_MISALIGN_TRAP_EN
    if (a.addr % nb != 0) e.bus = 0;
`endif
    e.strb = 4'(((64'd1 << nb) - 1) << off);
    e.wdata = 32'({32'd0, a.wd} << (8 * off));
    v = {32'd0, a.rd} >> (8 * off);
    m = (64'd1 << (8 * nb)) - 1;
    v = v & m;
    if (!a.uns && v[8*nb-1]) v = v | ~m;
    e.err = !e.bus || (!a.st && a.sz == 2'd3) || (a.st ? a.br[1] : a.rr[1]);
    e.rdata = (a.st || e.err) ? 32'd0 : v[31:0];
    e.cyc = !e.bus ? 1 : a.st ? 3 + (a.aw_d > a.w_d ? a.aw_d : a.w_d) + a.b_d : 3 + a.ar_d + a.r_d;
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issues one request and plays an AXI-lite slave with the given per-channel delays.
  task automatic run(input string nm, input acc_t a, output res_t r);
    int cyc, ar_c, aw_c, w_c, r_c, b_c;
    bit ar_dn, aw_dn, w_dn, r_dn, b_dn, p_ar, p_aw, p_w, h_ar, h_aw, h_w, h_r, h_b;
    bit [31:0] s_ar, s_aw, s_wd;
    bit [3:0] s_ws;
    r = '{default: 0};
    {ar_c, aw_c, w_c, r_c, b_c} = '0;
    {ar_dn, aw_dn, w_dn, r_dn, b_dn, p_ar, p_aw, p_w} = '0;
    {s_ar, s_aw, s_wd, s_ws} = '0;
    wait_idle();
    req_valid = 1; req_store = a.st; req_size = a.sz; req_unsigned = a.uns;
    req_addr = a.addr; req_wdata = a.wd;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 1;
    while (cyc < 40) begin
      if (p_ar && (!arvalid || araddr != s_ar)) r.viol++;
      if (p_aw && (!awvalid || awaddr != s_aw)) r.viol++;
      if (p_w && (!wvalid || wdata != s_wd || wstrb != s_ws)) r.viol++;
      if (bready && !(aw_dn && w_dn)) r.viol++;
      if (rready && !ar_dn) r.viol++;
      if (arvalid) begin r.saw_ar = 1; r.araddr = araddr; end
      if (awvalid) begin r.saw_aw = 1; r.awaddr = awaddr; end
      if (wvalid) begin r.saw_w = 1; r.wdata = wdata; r.strb = wstrb; end
      if (resp_valid) begin
        r.got = 1; r.cyc = cyc; r.rdata = resp_rdata; r.err = resp_err; r.load = resp_load;
        break;
      end
      arready = arvalid && ar_c >= a.ar_d;
      awready = awvalid && aw_c >= a.aw_d;
      wready = wvalid && w_c >= a.w_d;
      rvalid = ar_dn && !r_dn && r_c >= a.r_d;
      rdata = a.rd; rresp = a.rr;
      bvalid = aw_dn && w_dn && !b_dn && b_c >= a.b_d;
      bresp = a.br;
      ar_c += int'(arvalid); aw_c += int'(awvalid); w_c += int'(wvalid);
      r_c += int'(ar_dn); b_c += int'(aw_dn && w_dn);
      h_ar = arvalid && arready; h_aw = awvalid && awready; h_w = wvalid && wready;
      h_r = rvalid && rready; h_b = bvalid && bready;
      p_ar = arvalid && !arready; s_ar = araddr;
      p_aw = awvalid && !awready; s_aw = awaddr;
      p_w = wvalid && !wready; s_wd = wdata; s_ws = wstrb;
      @(posedge clk); #1;
      cyc++;
      ar_dn |= h_ar; aw_dn |= h_aw; w_dn |= h_w; r_dn |= h_r; b_dn |= h_b;
    end
    {arready, awready, wready, rvalid, bvalid} = '0;
    chk({nm, ".resp"}, r.got, 1);
    if (r.got) begin
      @(posedge clk); #1;
      chk({nm, ".pulse"}, {resp_valid, req_ready}, 2'b01);
    end
  endtask

  task automatic verify(input string nm, input acc_t a, input exp_t e, input res_t r);
    chk({nm, ".cyc"}, r.cyc, e.cyc);
    chk({nm, ".rdata"}, r.rdata, e.rdata);
    chk({nm, ".err"}, r.err, e.err);
    chk({nm, ".load"}, r.load, !a.st);
    chk({nm, ".proto"}, r.viol, 0);
    if (!e.bus) chk({nm, ".nobus"}, {r.saw_ar, r.saw_aw, r.saw_w}, 0);
    else if (a.st) begin
      chk({nm, ".noar"}, r.saw_ar, 0);
      chk({nm, ".awaddr"}, r.awaddr, a.addr);
      chk({nm, ".wdata"}, r.wdata, e.wdata);
      chk({nm, ".wstrb"}, r.strb, e.strb);
    end else begin
      chk({nm, ".noaw"}, {r.saw_aw, r.saw_w}, 0);
      chk({nm, ".araddr"}, r.araddr, a.addr);
    end
  endtask

  task automatic check_model(input string nm, input acc_t a);
    res_t r;
    run(nm, a, r);
    verify(nm, a, model(a), r);
  endtask

  task automatic reset_in_wr_b();
    acc_t a;
    wait_idle();
    req_valid = 1; req_store = 1; req_size = 2; req_unsigned = 0;
    req_addr = 32'h40000008; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    req_valid = 0; awready = 1; wready = 1;
    @(posedge clk); #1;
    awready = 0; wready = 0;
    chk("rst.in_wr_b", bready, 1);
    #2 rst = 0;
    #1;
    chk("rst.ready", req_ready, 1);
    chk("rst.ctrl", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_load, resp_err, wstrb}, 0);
    chk("rst.addr", {awaddr, araddr}, 0);
    chk("rst.data", {wdata, resp_rdata}, 0);
    bvalid = 1; bresp = 0;
    @(posedge clk); #1;
    chk("rst.held", {resp_valid, req_ready}, 2'b01);
    rst = 1; bvalid = 0;
    @(posedge clk); #1;
    chk("rst.fresh", {resp_valid, bready, req_ready}, 3'b001);
    a = '{0, 2'd2, 0, 32'h40000010, 0, 32'h600DCAFE, 0, 0, 0, 0, 0, 0, 0};
    check_model("rst.next", a);
  endtask

  vec_t tab[12];
  initial begin
    tab[0]  = '{'{0, 2'd2, 0, 32'h80000004, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0}, '{32'hDEADBEEF, 0, 3, 0, 0, 1}};
    tab[1]  = '{'{0, 2'd0, 0, 32'h80000003, 0, 32'h80112233, 0, 0, 0, 0, 0, 0, 0}, '{32'hFFFFFF80, 0, 3, 0, 0, 1}};
    tab[2]  = '{'{0, 2'd0, 1, 32'h80000003, 0, 32'h80112233, 0, 0, 0, 0, 0, 0, 0}, '{32'h00000080, 0, 3, 0, 0, 1}};
    tab[3]  = '{'{1, 2'd1, 0, 32'h80000002, 32'h1234, 0, 0, 0, 0, 3, 0, 0, 0}, '{0, 0, 6, 4'hC, 32'h12340000, 1}};
    tab[4]  = '{'{0, 2'd2, 0, 32'h80000010, 0, 32'h55AA55AA, 2'b10, 0, 0, 0, 1, 0, 0}, '{0, 1, 4, 0, 0, 1}};
    tab[5]  = '{'{0, 2'd1, 0, 32'h20000002, 0, 32'h80017FFF, 0, 0, 0, 0, 2, 1, 0}, '{32'hFFFF8001, 0, 6, 0, 0, 1}};
    tab[6]  = '{'{0, 2'd1, 1, 32'h20000000, 0, 32'h1234ABCD, 0, 0, 0, 0, 0, 2, 0}, '{32'h0000ABCD, 0, 5, 0, 0, 1}};
    tab[7]  = '{'{1, 2'd0, 0, 32'h30000001, 32'hFFFFFFA5, 0, 0, 2'b10, 2, 0, 0, 0, 1}, '{0, 1, 6, 4'h2, 32'hFFFFA500, 1}};
    tab[8]  = '{'{1, 2'd2, 0, 32'h00000010, 32'hCAFEF00D, 0, 0, 0, 2, 1, 0, 0, 0}, '{0, 0, 5, 4'hF, 32'hCAFEF00D, 1}};
    tab[9]  = '{'{0, 2'd3, 0, 32'h00000008, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0}, '{0, 1, 3, 0, 0, 1}};
    tab[10] = '{'{0, 2'd0, 0, 32'h00000101, 0, 32'h00007F00, 0, 0, 0, 0, 0, 0, 0}, '{32'h0000007F, 0, 3, 0, 0, 1}};
    tab[11] = '{'{0, 2'd2, 0, 32'h00000200, 0, 32'h11112222, 2'b01, 0, 0, 0, 0, 0, 0}, '{32'h11112222, 0, 3, 0, 0, 1}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", req_ready, 1);
    chk("reset.ctrl", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_load, resp_err, wstrb}, 0);
    chk("reset.data", {wdata, resp_rdata}, 0);
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      res_t r;
      run($sformatf("vec%0d", i), tab[i].a, r);
      verify($sformatf("vec%0d", i), tab[i].a, tab[i].e, r);
    end

    check_model("misalign.ld", '{0, 2'd2, 0, 32'h80000101, 0, 32'h44332211, 0, 0, 0, 0, 0, 0, 0});
    check_model("misalign.st", '{1, 2'd2, 0, 32'h80000103, 32'hA1B2C3D4, 0, 0, 0, 1, 0, 0, 0, 0});
    reset_in_wr_b();

    for (int i = 0; i < 200; i++) begin
      acc_t a;
      a.st = 1'($urandom); a.sz = 2'($urandom); a.uns = 1'($urandom);
      a.addr = $urandom; a.wd = $urandom; a.rd = $urandom;
      a.rr = 2'($urandom); a.br = 2'($urandom);
      a.aw_d = $urandom_range(0, 3); a.w_d = $urandom_range(0, 3);
      a.ar_d = $urandom_range(0, 3); a.r_d = $urandom_range(0, 3); a.b_d = $urandom_range(0, 3);
      check_model($sformatf("rnd%0d", i), a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
